// File: rtl/mda_attr_serializer.sv
// MDA character-to-pixel stage.
// Decodes the attribute byte of each loaded character into a 9-pixel pattern
// and shifts it out MSB first, one pixel per pix_ce, as {video, intensity}.
module mda_attr_serializer #(
    parameter logic [4:0] UL_ROW    = 5'd12,
    parameter int         BLINK_BIT = 4,
    parameter int         CURS_BIT  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic       char_load,
    input  logic [7:0] char_code,
    input  logic [7:0] attr,
    input  logic [7:0] font_row,
    input  logic [4:0] row_addr,
    input  logic       cursor_active,
    input  logic       display_enable,
    input  logic       blink_en,
    input  logic       vsync,
    output logic       video,
    output logic       intensity
);

    logic [4:0] frame_cnt;
    logic       vsync_q;
    logic [8:0] shifter;
    logic [3:0] pix_cnt;
    logic       int_latch;

    logic       c9;
    logic [8:0] glyph;
    logic       is_blank;
    logic       is_rev;
    logic       is_ul;
    logic       blink_hide;
    logic       curs_on;
    logic [8:0] pattern;
    logic       int_next;
    logic       video_next;
    logic       load;

    assign load       = pix_ce & char_load;
    assign video_next = shifter[8] & display_enable;

    // Frame counter advances on each vsync rising edge, regardless of pix_ce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q   <= 1'b0;
            frame_cnt <= 5'd0;
        end else begin
            vsync_q <= vsync;
            if (vsync & ~vsync_q) begin
                frame_cnt <= frame_cnt + 5'd1;
            end
        end
    end

    // Attribute decode of the character presented for loading.
    always_comb begin
        c9         = (char_code >= 8'hC0 && char_code <= 8'hDF) ? font_row[0] : 1'b0;
        glyph      = {font_row, c9};
        is_blank   = (attr & 8'h77) == 8'h00;
        is_rev     = (attr[6:4] == 3'b111) && (attr[2:0] == 3'b000);
        is_ul      = (attr[2:0] == 3'b001) && (row_addr == UL_ROW);
        blink_hide = blink_en & attr[7] & ~frame_cnt[BLINK_BIT];
        curs_on    = cursor_active & frame_cnt[CURS_BIT] & (row_addr >= (UL_ROW - 5'd1));

        pattern = glyph;
        if (is_blank) begin
            pattern = 9'h000;
        end else if (is_rev) begin
            pattern = ~glyph;
        end else if (is_ul) begin
            pattern = 9'h1FF;
        end

        // Blinking hides the glyph but keeps the cell background.
        if (blink_hide) begin
            pattern = is_rev ? 9'h1FF : 9'h000;
        end

        if (curs_on) begin
            pattern = 9'h1FF;
        end

        int_next = is_rev ? (~blink_en & attr[7]) : attr[3];
    end

    // Pixel shifter, pixel counter and registered outputs, all gated by pix_ce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shifter   <= 9'h000;
            pix_cnt   <= 4'd0;
            int_latch <= 1'b0;
            video     <= 1'b0;
            intensity <= 1'b0;
        end else if (pix_ce) begin
            video     <= video_next;
            intensity <= int_latch & video_next;
            if (load) begin
                shifter   <= pattern;
                pix_cnt   <= 4'd0;
                int_latch <= int_next;
            end else if (pix_cnt == 4'd8) begin
                // Last pixel already presented; keep shifting out black.
                shifter <= 9'h000;
            end else begin
                shifter <= {shifter[7:0], 1'b0};
                pix_cnt <= pix_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mda_attr_serializer.sv
// Bench for mda_attr_serializer: directed and randomized characters checked
// against a pixel-list reference model.
module tb_mda_attr_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_ce;
    logic       char_load;
    logic [7:0] char_code;
    logic [7:0] attr;
    logic [7:0] font_row;
    logic [4:0] row_addr;
    logic       cursor_active;
    logic       display_enable;
    logic       blink_en;
    logic       vsync;
    logic       video;
    logic       intensity;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int fc;              // vsync pulses seen, modulo 32
    bit prev_vs;
    bit cur_pix [9];     // pixels of the current character, left to right
    int pos;             // index of next pixel to present; 9 = exhausted
    bit lat;             // intensity of the current character
    bit m_video;
    bit m_int;

    mda_attr_serializer dut (
        .clk           (clk),
        .reset         (reset),
        .pix_ce        (pix_ce),
        .char_load     (char_load),
        .char_code     (char_code),
        .attr          (attr),
        .font_row      (font_row),
        .row_addr      (row_addr),
        .cursor_active (cursor_active),
        .display_enable(display_enable),
        .blink_en      (blink_en),
        .vsync         (vsync),
        .video         (video),
        .intensity     (intensity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        fc = 0; prev_vs = 0; pos = 9; lat = 0; m_video = 0; m_int = 0;
        for (int k = 0; k < 9; k++) cur_pix[k] = 0;
    endtask

    // Applies the character rules to the present inputs and the frame count.
    task automatic model_load();
        bit blank, rev, ul, hide, curs, c9, g;
        int ph;
        ph    = fc;
        blank = (attr & 8'h77) == 0;
        rev   = (attr[6:4] == 3'd7) && (attr[2:0] == 3'd0);
        ul    = (attr[2:0] == 3'd1) && (row_addr == 12);
        hide  = blink_en && attr[7] && ((ph / 16) % 2 == 0);
        curs  = cursor_active && ((ph / 8) % 2 == 1) && (row_addr >= 11);
        c9    = (char_code >= 8'hC0 && char_code <= 8'hDF) ? font_row[0] : 1'b0;
        for (int k = 0; k < 9; k++) begin
            g = (k < 8) ? font_row[7 - k] : c9;
            if (blank)      cur_pix[k] = 0;
            else if (rev)   cur_pix[k] = !g;
            else if (ul)    cur_pix[k] = 1;
            else            cur_pix[k] = g;
            if (hide) cur_pix[k] = rev;
            if (curs) cur_pix[k] = 1;
        end
        lat = rev ? (!blink_en && attr[7]) : attr[3];
        pos = 0;
    endtask

    task automatic model_edge();
        bit v;
        if (pix_ce) begin
            v       = (pos < 9) ? cur_pix[pos] : 1'b0;
            v       = v && display_enable;
            m_video = v;
            m_int   = lat && v;
            if (char_load) model_load();
            else if (pos < 9) pos++;
        end
        if (vsync && !prev_vs) fc = (fc + 1) % 32;
        prev_vs = vsync;
    endtask

    task automatic cyc(input logic pce, input logic ld);
        pix_ce    = pce;
        char_load = ld;
        @(posedge clk);
        model_edge();
        #1;
        chk("video", video, m_video);
        chk("intensity", intensity, m_int);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        cyc(1'b0, 1'b0);
        vsync = 1'b0;
        cyc(1'b0, 1'b0);
    endtask

    // Loads one character, then n further pixel enables with random idle gaps.
    task automatic run_char(input logic [7:0] c, input logic [7:0] a, input logic [7:0] f,
                            input logic [4:0] r, input logic cur, input int n);
        char_code = c; attr = a; font_row = f; row_addr = r; cursor_active = cur;
        $display("char code=%h attr=%h font=%h row=%0d cur=%b blink_en=%b de=%b frame=%0d pix=%0d",
                 c, a, f, r, cur, blink_en, display_enable, fc, n);
        cyc(1'b1, 1'b1);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'($urandom_range(0, 1)));
            cyc(1'b1, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] attr_tab [10];
        attr_tab = '{8'h07, 8'h0F, 8'h70, 8'hF0, 8'h01, 8'h09, 8'h87, 8'h8F, 8'h00, 8'h78};

        reset = 1'b1; pix_ce = 0; char_load = 0; char_code = 0; attr = 0; font_row = 0;
        row_addr = 0; cursor_active = 0; display_enable = 1; blink_en = 0; vsync = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_video", video, 1'b0);
        chk("reset_intensity", intensity, 1'b0);
        reset = 1'b0;

        // Directed attribute cases
        run_char(8'h41, 8'h07, 8'hAA, 5'd0, 1'b0, 10);
        run_char(8'hC4, 8'h0F, 8'hFF, 5'd0, 1'b0, 10);
        run_char(8'h41, 8'h0F, 8'hFF, 5'd0, 1'b0, 10);
        run_char(8'hC4, 8'h70, 8'hF0, 5'd0, 1'b0, 10);
        run_char(8'hC5, 8'h70, 8'hF1, 5'd0, 1'b0, 10);
        run_char(8'h41, 8'h00, 8'hFF, 5'd0, 1'b0, 10);
        run_char(8'h41, 8'h01, 8'h00, 5'd12, 1'b0, 10);
        run_char(8'h41, 8'h01, 8'h00, 5'd11, 1'b0, 10);

        // Blink and cursor phases across the frame counter
        for (int b = 0; b < 2; b++) begin
            blink_en = 1'(b);
            for (int s = 0; s < 8; s++) begin
                run_char(8'h41, 8'h87, 8'hAA, 5'd3, 1'b0, 9);
                run_char(8'h41, 8'hF0, 8'hAA, 5'd3, 1'b0, 9);
                run_char(8'h41, 8'h07, 8'h00, 5'd13, 1'b1, 9);
                run_char(8'h41, 8'h07, 8'h00, 5'd10, 1'b1, 9);
                repeat (4) vsync_pulse();
            end
        end

        // vsync edge in the same cycle as a load: load sees the old phase
        blink_en = 1'b1;
        for (int k = 0; k < 32 && fc != 15; k++) vsync_pulse();
        chk("frame_at_15", 1'(fc == 15), 1'b1);
        char_code = 8'h41; attr = 8'h87; font_row = 8'hFF; row_addr = 5'd2; cursor_active = 0;
        vsync = 1'b1;
        cyc(1'b1, 1'b1);
        vsync = 1'b0;
        repeat (10) cyc(1'b1, 1'b0);
        run_char(8'h41, 8'h87, 8'hFF, 5'd2, 1'b0, 9);

        // Reload every 5 pixel enables truncates each character
        blink_en = 1'b0;
        for (int k = 0; k < 4; k++) run_char(8'hC0 + 8'(k), 8'h0F, 8'($urandom), 5'd0, 1'b0, 4);

        // Randomized characters
        for (int k = 0; k < 40; k++) begin
            blink_en       = 1'($urandom_range(0, 1));
            display_enable = ($urandom_range(0, 5) != 0);
            run_char(8'($urandom_range(8'hB8, 8'hE7)), attr_tab[$urandom_range(0, 9)],
                     8'($urandom), 5'($urandom_range(9, 13)), 1'($urandom_range(0, 1)),
                     $urandom_range(3, 10));
            if ($urandom_range(0, 2) == 0) vsync_pulse();
        end
        display_enable = 1'b1;

        // Reset in the middle of a character clears the outputs immediately
        blink_en = 1'b0;
        run_char(8'h41, 8'h0F, 8'hFF, 5'd0, 1'b0, 3);
        chk("pre_reset_video", video, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("midreset_video", video, 1'b0);
        chk("midreset_intensity", intensity, 1'b0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) cyc(1'b1, 1'b0);
        blink_en = 1'b1;
        run_char(8'h41, 8'h87, 8'hFF, 5'd0, 1'b0, 10);
        run_char(8'h41, 8'h0F, 8'h81, 5'd0, 1'b0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
